// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: pipeline register with a valid/ready handshake and a
// one-entry skid buffer. The main register always holds the head entry and
// drives out_data. The skid register catches the one extra beat that can
// arrive after downstream stalls. in_ready comes only from the state flops,
// so the ready path never combinationally crosses the stage.
module pipe_reg_skid #(
  parameter int unsigned     N           = 32,
  parameter logic [N-1:0]    RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         in_xfer, out_xfer;

  assign count     = state_q;
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Next occupancy and register contents; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and data registers; reset empties the stage immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Occupancy 3 has no meaning and must never be reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (state_q != 2'd3);
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed scenarios plus a randomised scoreboard run
// for the skid-buffered pipeline register.
module tb_pipe_reg_skid;

  localparam int unsigned  N  = 32;
  localparam logic [N-1:0] RV = 32'hBFC0_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   count;

  int errors = 0;
  int checks = 0;

  pipe_reg_skid #(.N(N), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all visible outputs against expected values.
  task automatic expect_state(input string name, input logic [1:0] c,
                              input logic v, input logic r,
                              input logic [N-1:0] d);
    checks++;
    if (count !== c || out_valid !== v || in_ready !== r || out_data !== d) begin
      errors++;
      $display("[TB] FAIL %s: got count=%0d valid=%b ready=%b data=%h, want count=%0d valid=%b ready=%b data=%h",
               name, count, out_valid, in_ready, out_data, c, v, r, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    expect_state("reset_held", 2'd0, 1'b0, 1'b1, RV);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_00AA;
    step();
    in_valid = 1'b0;
    expect_state("first_push", 2'd1, 1'b1, 1'b1, 32'h0000_00AA);
    // reset between edges must act without a clock edge
    #2 rst = 1'b1;
    #1;
    expect_state("async_reset", 2'd0, 1'b0, 1'b1, RV);
    #3 rst = 1'b0;
  endtask

  task automatic test_streaming();
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = N'(i);
      step();
      expect_state($sformatf("stream_%0d", i), 2'd1, 1'b1, 1'b1, N'(i));
    end
    in_valid = 1'b0;
    step();
    expect_state("stream_drain", 2'd0, 1'b0, 1'b1, 32'd4);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_000A;
    step();
    expect_state("bp_A", 2'd1, 1'b1, 1'b1, 32'h0000_000A);
    in_data = 32'h0000_000B;
    step();
    expect_state("bp_B_full", 2'd2, 1'b1, 1'b0, 32'h0000_000A);
    in_data = 32'h0000_000C;
    step();
    expect_state("bp_C_held", 2'd2, 1'b1, 1'b0, 32'h0000_000A);
    out_ready = 1'b1;
    step();
    expect_state("bp_out_B", 2'd1, 1'b1, 1'b1, 32'h0000_000B);
    step();
    expect_state("bp_out_C", 2'd1, 1'b1, 1'b1, 32'h0000_000C);
    in_valid = 1'b0;
    step();
    expect_state("bp_empty", 2'd0, 1'b0, 1'b1, 32'h0000_000C);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_1111;
    step();
    in_data = 32'h0000_2222;
    step();
    expect_state("fl_full", 2'd2, 1'b1, 1'b0, 32'h0000_1111);
    in_data = 32'h0000_DEAD; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    expect_state("fl_from_full", 2'd0, 1'b0, 1'b1, RV);
    out_ready = 1'b0; in_data = 32'h0000_3333;
    step();
    expect_state("fl_one", 2'd1, 1'b1, 1'b1, 32'h0000_3333);
    in_data = 32'h0000_BEEF; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    expect_state("fl_from_one", 2'd0, 1'b0, 1'b1, RV);
    step();
    expect_state("fl_discarded", 2'd0, 1'b0, 1'b1, RV);
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0011;
    step();
    in_data = 32'h0000_0022;
    step();
    in_valid = 1'b0;
    expect_state("mr_full", 2'd2, 1'b1, 1'b0, 32'h0000_0011);
    #2 rst = 1'b1;
    #1;
    expect_state("mr_reset", 2'd0, 1'b0, 1'b1, RV);
    #4 rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0055;
    #1;
    expect_state("mr_before_edge", 2'd0, 1'b0, 1'b1, RV);
    step();
    in_valid = 1'b0;
    expect_state("mr_push55", 2'd1, 1'b1, 1'b1, 32'h0000_0055);
  endtask

  task automatic test_random();
    logic [N-1:0] q[$];
    logic         exp_ready, exp_valid, in_x, out_x;
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    flush = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = $urandom;
      exp_ready = (q.size() != 2);
      exp_valid = (q.size() != 0);
      checks++;
      if (count !== 2'(q.size()) || in_ready !== exp_ready || out_valid !== exp_valid) begin
        errors++;
        $display("[TB] FAIL rnd_ctrl cyc %0d: got count=%0d ready=%b valid=%b, want count=%0d ready=%b valid=%b",
                 cyc, count, in_ready, out_valid, q.size(), exp_ready, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (out_data !== q[0]) begin
          errors++;
          $display("[TB] FAIL rnd_data cyc %0d: got %h, want %h", cyc, out_data, q[0]);
        end
      end
      in_x  = in_valid && exp_ready;
      out_x = exp_valid && out_ready;
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(in_data);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
# pipe_reg_skid

Parametrised pipeline register with a valid/ready handshake and a one-entry skid buffer, for stage boundaries in the MIPS datapath that must stall or flush. It replaces a plain reset register wherever back-pressure is needed. It sustains one transfer per cycle. `in_ready` is driven only from flops, so the ready path does not combinationally cross the stage.

## Interface
- `N`, 32: data width, N >= 1
- `RESET_VALUE`, 0 (N bits): value loaded into both data registers on reset and flush

- `clk` input 1: clock, rising edge
- `rst` input 1: asynchronous reset, active-high
- `flush` input 1: synchronous discard of all held entries
- `in_valid` input 1: upstream offers `in_data`
- `in_ready` output 1: block can accept; registered
- `in_data` input N: upstream data
- `out_valid` output 1: `out_data` holds a valid entry
- `out_ready` input 1: downstream accepts
- `out_data` output N: head entry; registered, equal to the main register
- `count` output 2: entries held (0, 1 or 2)

## Operation
- Storage: main register (drives `out_data`) and skid register; state tracked by `count`.
- Input transfer = `in_valid && in_ready`. Output transfer = `out_valid && out_ready`.
- `out_valid = (count != 0)`. `in_ready = (count != 2)`, derived from registered state only.
- State EMPTY (`count`=0):
  - input transfer -> main <= `in_data`, go to ONE.
- State ONE (`count`=1):
  - input and output transfer -> main <= `in_data`, stay in ONE.
  - input transfer only -> skid <= `in_data`, go to FULL.
  - output transfer only -> go to EMPTY.
  - neither -> hold.
- State FULL (`count`=2), `in_ready`=0:
  - output transfer -> main <= skid, go to ONE.
  - otherwise hold.
- Data registers load only on the events above and otherwise hold. After draining to EMPTY, `out_data` retains its last value.
- `flush` has priority over everything else:
  - next state is EMPTY; main and skid <= `RESET_VALUE`.
  - Any input or output transfer in the flush cycle still counts as a handshake, but the input data is discarded.
- Order is preserved: skid contents always follow main.
- `count` = 3 is unreachable. If it is ever observed, treat it as an assertion failure.

## Timing
- Reset (asynchronous, immediate on `rst` high, held while high):
  - `count`=0, `out_valid`=0, `in_ready`=1
  - `out_data`=`RESET_VALUE`, skid=`RESET_VALUE`
- First input transfer may occur in the first rising edge after `rst` deasserts.
- Latency: data accepted at edge k is at `out_data` with `out_valid`=1 after edge k, so it is visible in cycle k+1.
- Throughput: 1 transfer/cycle with `out_ready` held high; `count` stays at 1.
- Stall: `in_ready` drops the cycle after the skid fills. At most one extra beat is absorbed after `out_ready` falls.
- Recovery from FULL: `in_ready` returns to 1 the cycle after an output transfer.
- Flush at edge k: from cycle k+1, `out_valid`=0, `in_ready`=1, `count`=0.
- `rst` asserted mid-operation: all held entries are lost at once; outputs return to their reset values without waiting for a clock edge.

## Test plan
- Reset: `N`=32, `RESET_VALUE`=32'hBFC0_0000, assert `rst` between edges -> without a clock edge, `out_data`=BFC0_0000, `out_valid`=0, `in_ready`=1, `count`=0.
- Streaming: `out_ready`=1, push 1,2,3,4 on consecutive cycles -> `out_data` = 1,2,3,4 one cycle later each; `count` stays 1; no bubbles.
- Back-pressure:
  - Push A, B, C with `out_ready`=0 -> A and B accepted, `count`=2, `in_ready`=0, C held by upstream.
  - Then raise `out_ready` -> outputs A, B, C in order; `in_ready` returns one cycle after A leaves.
- Flush while FULL with a simultaneous input and output transfer -> next cycle `count`=0, `out_valid`=0, `out_data`=`RESET_VALUE`; the flush-cycle input never appears at the output.
- Mid-operation reset: pulse `rst` for half a cycle while `count`=2 -> outputs reach reset values immediately; the next pushed value 0x55 appears one cycle after acceptance.
- Randomised `in_valid`/`out_ready` over 10k cycles against a FIFO scoreboard -> no loss, duplication or reordering; `count` never exceeds 2.
